window_regfile: RTL and testbench

- Windowed register file that sits directly downstream of the single-cycle controller.
- Consumes the controller's register-write enable and window-change strobe together with the instruction's register fields and func byte.
- Supplies the two ALU source operands and accepts the write-back value.
- Implements overlapping register windows: a current window pointer (CWP) selects which physical registers the logical register numbers map to.

---
 rtl/window_regfile_pkg.sv | 28 ++
 rtl/window_regfile_if.sv | 26 ++
 rtl/window_regfile.sv | 57 +++++
 tb/tb_window_regfile.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/window_regfile_pkg.sv
// Constants, typedefs and the logical-to-physical register mapping shared
// by the controller, the datapath and the register file.
package window_regfile_pkg;

   localparam int DATA_W = 8;
   localparam int NWIN   = 4;
   localparam int LREGS  = 4;
   localparam int STRIDE = 2;
   localparam int PREGS  = NWIN * STRIDE;

   localparam int LREG_W = $clog2(LREGS);
   localparam int PIDX_W = $clog2(PREGS);
   localparam int WPTR_W = $clog2(NWIN);
   localparam int SUM_W  = PIDX_W + 1;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [LREG_W-1:0] lreg_t;
   typedef logic [PIDX_W-1:0] pidx_t;
   typedef logic [WPTR_W-1:0] wptr_t;

   // PREGS is a power of two, so dropping the carry bit is the modulo.
   function automatic pidx_t phys_idx(input wptr_t w, input lreg_t l);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(w) * SUM_W'(STRIDE) + SUM_W'(l);
      return sum[PIDX_W-1:0];
   endfunction

endpackage

// File: rtl/window_regfile_if.sv
// Controller/datapath-facing bus of the windowed register file.
interface window_regfile_if;
   import window_regfile_pkg::*;

   lreg_t        ra1;
   lreg_t        ra2;
   data_t        rd1;
   data_t        rd2;
   lreg_t        wa;
   data_t        wd;
   logic         regWriteEn;
   logic         changewnd;
   logic [7:0]   func;
   wptr_t        cwp;

   modport master (
      output ra1, ra2, wa, wd, regWriteEn, changewnd, func,
      input  rd1, rd2, cwp
   );

   modport slave (
      input  ra1, ra2, wa, wd, regWriteEn, changewnd, func,
      output rd1, rd2, cwp
   );

endinterface

// File: rtl/window_regfile.sv
// Windowed register file: overlapping windows selected by a registered CWP,
// two combinational read ports and one clocked write port.
module window_regfile
   import window_regfile_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   window_regfile_if.slave  bus
);

   wptr_t cwp_reg;
   data_t regs [PREGS];
   pidx_t wr_idx;
   logic  unused_func;

   // Write index uses the pre-edge window, so a write paired with a window
   // change lands in the old window.
   assign wr_idx = phys_idx(cwp_reg, bus.wa);

   genvar gi;
   generate
      for (gi = 0; gi < PREGS; gi++) begin : g_preg
         data_t val_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               val_reg <= '0;
            end else if (bus.regWriteEn == 1'b1 && wr_idx == pidx_t'(gi)) begin
               val_reg <= bus.wd;
            end
         end

         assign regs[gi] = val_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cwp_reg <= '0;
      end else if (bus.changewnd == 1'b1) begin
         cwp_reg <= bus.func[WPTR_W-1:0];
      end
   end

   assign bus.rd1 = regs[phys_idx(cwp_reg, bus.ra1)];
   assign bus.rd2 = regs[phys_idx(cwp_reg, bus.ra2)];
   assign bus.cwp = cwp_reg;

   // Only the low func bits select a window.
   assign unused_func = ^bus.func[7:WPTR_W];

   a_strobes_known: assert property (
      @(posedge clk) disable iff (!rst_n)
      !$isunknown(bus.regWriteEn) && !$isunknown(bus.changewnd)
   );

endmodule

// File: tb/tb_window_regfile.sv
// Randomised and directed checks of window_regfile against a flat-array model.
module tb_window_regfile;
   import window_regfile_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   window_regfile_if bus();

   window_regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   data_t mdl_mem [PREGS];
   int    mdl_cwp;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pmap(input int w, input int l);
      return (w * STRIDE + l) % PREGS;
   endfunction

   function automatic data_t mdl_read(input int l);
      return mdl_mem[pmap(mdl_cwp, l)];
   endfunction

   task automatic mdl_clear();
      for (int i = 0; i < PREGS; i++) mdl_mem[i] = '0;
      mdl_cwp = 0;
   endtask

   task automatic read_chk(input string tag, input int a1, input int a2);
      bus.ra1 = lreg_t'(a1);
      bus.ra2 = lreg_t'(a2);
      #1;
      check_val({tag, "_rd1"}, 32'(bus.rd1), 32'(mdl_read(a1)));
      check_val({tag, "_rd2"}, 32'(bus.rd2), 32'(mdl_read(a2)));
      check_val({tag, "_cwp"}, 32'(bus.cwp), 32'(mdl_cwp));
   endtask

   // One clock: drive at negedge, confirm no bypass before the edge, then
   // apply the same transaction to the model after the edge.
   task automatic cycle(input bit we, input int a, input data_t d, input bit cw,
                        input logic [7:0] f, input string tag);
      @(negedge clk);
      bus.regWriteEn = we;
      bus.wa         = lreg_t'(a);
      bus.wd         = d;
      bus.changewnd  = cw;
      bus.func       = f;
      bus.ra1        = lreg_t'(a);
      bus.ra2        = lreg_t'($urandom_range(0, LREGS - 1));
      #1;
      check_val({tag, "_nobypass"}, 32'(bus.rd1), 32'(mdl_read(a)));
      @(posedge clk);
      if (rst_n) begin
         if (we) mdl_mem[pmap(mdl_cwp, a)] = d;
         if (cw) mdl_cwp = int'(f) % NWIN;
      end
      #1;
      bus.regWriteEn = 1'b0;
      bus.changewnd  = 1'b0;
      $display("txn %s we=%0b wa=%0d wd=%02h cw=%0b func=%02h cwp=%0d",
               tag, we, a, d, cw, f, bus.cwp);
   endtask

   initial begin
      bus.ra1 = '0; bus.ra2 = '0; bus.wa = '0; bus.wd = '0;
      bus.regWriteEn = 1'b0; bus.changewnd = 1'b0; bus.func = '0;
      mdl_clear();

      // Reset held, then released
      #12;
      read_chk("rst_held", 1, 3);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < LREGS; i++)
         for (int j = 0; j < LREGS; j++)
            read_chk("rst_rel", i, j);

      // Basic write/read
      cycle(1'b1, 2, 8'hA5, 1'b0, 8'h00, "basic");
      read_chk("basic", 2, 0);
      check_val("basic_const", 32'(bus.rd1), 32'h0000_00A5);
      read_chk("basic_other", 1, 3);

      // Overlap alias window 0 -> 1
      cycle(1'b1, 2, 8'h11, 1'b0, 8'h00, "ovl_w2");
      cycle(1'b1, 3, 8'h22, 1'b0, 8'h00, "ovl_w3");
      cycle(1'b0, 0, 8'h00, 1'b1, 8'h81, "ovl_chg");
      read_chk("ovl", 0, 1);
      check_val("ovl_r0", 32'(bus.rd1), 32'h11);
      check_val("ovl_r1", 32'(bus.rd2), 32'h22);
      check_val("ovl_cwp", 32'(bus.cwp), 32'd1);

      // Wrap-around window 3 -> 0
      cycle(1'b0, 0, 8'h00, 1'b1, 8'h03, "wrap_chg3");
      cycle(1'b1, 2, 8'h5C, 1'b0, 8'h00, "wrap_wr");
      cycle(1'b0, 0, 8'h00, 1'b1, 8'h80, "wrap_chg0");
      read_chk("wrap", 0, 2);
      check_val("wrap_r0", 32'(bus.rd1), 32'h5C);

      // Simultaneous write + window change: write goes to the old window
      cycle(1'b1, 0, 8'h3C, 1'b1, 8'h82, "simul");
      read_chk("simul_w2", 0, 1);
      check_val("simul_cwp", 32'(bus.cwp), 32'd2);
      check_val("simul_p4", 32'(bus.rd1), 32'h0);
      cycle(1'b0, 0, 8'h00, 1'b1, 8'h00, "simul_back");
      read_chk("simul_w0", 0, 2);
      check_val("simul_r0", 32'(bus.rd1), 32'h3C);

      // Selecting the current window is a no-op
      cycle(1'b0, 0, 8'h00, 1'b1, 8'hFC, "same_win");
      read_chk("same_win", 0, 3);

      // Randomised traffic
      for (int n = 0; n < 200; n++) begin
         cycle(1'($urandom), $urandom_range(0, LREGS - 1), data_t'($urandom),
               ($urandom_range(0, 3) == 0), 8'($urandom), "rand");
         read_chk("rand", $urandom_range(0, LREGS - 1), $urandom_range(0, LREGS - 1));
      end

      // Make sure something is non-zero before the async reset
      cycle(1'b1, 1, 8'hE7, 1'b1, 8'h02, "pre_rst");
      read_chk("pre_rst", 1, 0);

      // Asynchronous reset between edges
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_rd1", 32'(bus.rd1), 32'h0);
      check_val("arst_cwp", 32'(bus.cwp), 32'h0);
      mdl_clear();
      read_chk("arst", 1, 2);

      // Strobes during reset are discarded
      cycle(1'b1, 1, 8'hFF, 1'b1, 8'h03, "in_rst");
      read_chk("in_rst", 1, 3);

      // Strobes coinciding with reset release take effect on the first edge
      @(negedge clk);
      rst_n          = 1'b1;
      bus.regWriteEn = 1'b1;
      bus.wa         = 2'd1;
      bus.wd         = 8'h77;
      bus.changewnd  = 1'b1;
      bus.func       = 8'h01;
      @(posedge clk);
      mdl_mem[pmap(mdl_cwp, 1)] = 8'h77;
      mdl_cwp = 1;
      #1;
      bus.regWriteEn = 1'b0;
      bus.changewnd  = 1'b0;
      $display("txn rel_wr we=1 wa=1 wd=77 cw=1 func=01 cwp=%0d", bus.cwp);
      read_chk("rel_wr", 3, 0);
      cycle(1'b0, 0, 8'h00, 1'b1, 8'h00, "rel_back");
      read_chk("rel_back", 1, 3);
      check_val("rel_p1", 32'(bus.rd1), 32'h77);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
